// File: rtl/led_scan_pkg.sv
// Shared state encoding, geometry and row decode for the LED scan scheduler.
package led_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam int         ROWS     = 9;
    localparam int         COL_W    = 8;
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    // Row 0 lands on the MSB so {SEG7_CA, MATRIX_ROW} wires straight through.
    function automatic logic [ROWS-1:0] row_onehot(input logic [3:0] row);
        logic [ROWS-1:0] oh;
        oh = '0;
        if (row <= LAST_ROW)
            oh[LAST_ROW - row] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/led_scan_buf.sv
// Double-buffered 2x9x8 frame store: writes go to the back half, reads come from the front half.
module led_scan_buf
    import led_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_row,
    input  logic [COL_W-1:0] wr_data,
    input  logic             swap,
    input  logic [3:0]       rd_row,
    output logic [COL_W-1:0] rd_data
);

    logic [COL_W-1:0] mem [2][ROWS];
    logic             front_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    mem[b][r] <= '0;
        end else begin
            // A write on the swap edge still targets the old back half, so it shows in the new frame.
            if (wr_en && (wr_row <= LAST_ROW))
                mem[~front_sel][wr_row] <= wr_data;
            if (swap)
                front_sel <= ~front_sel;
        end
    end

    assign rd_data = (rd_row <= LAST_ROW) ? mem[front_sel][rd_row] : '0;

endmodule

// File: rtl/led_scan_ctrl.sv
// Row scan scheduler: one-hot row drive with dwell/blank timing and frame-aligned buffer swaps.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int DWELL = 16384,
    parameter int BLANK = 64
) (
    input  logic             XTAL_IN,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             WR_EN,
    input  logic [3:0]       WR_ROW,
    input  logic [COL_W-1:0] WR_DATA,
    input  logic             SWAP_REQ,
    output logic             SWAP_PEND,
    output logic             SWAP_ACK,
    output logic [ROWS-1:0]  ROW_SEL,
    output logic [COL_W-1:0] COL,
    output logic             FRAME_START
);

    localparam int PH_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam bit HAS_BLANK = (BLANK > 0);
    localparam logic [PH_W-1:0] DWELL_LAST = PH_W'(DWELL - 1);
    localparam logic [PH_W-1:0] BLANK_LAST = PH_W'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_t      state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [PH_W-1:0]  cnt_q, cnt_d;
    logic             pend_q;
    logic             swap_apply;
    logic [COL_W-1:0] front_data;

    always_ff @(posedge XTAL_IN) begin
        if (RST) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            // A request arriving on the apply edge is kept for the following frame.
            pend_q  <= swap_apply ? SWAP_REQ : (pend_q | SWAP_REQ);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        if (!ENABLE) begin
            state_d = ST_IDLE;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q + PH_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = '0;
                        row_d   = (row_q >= LAST_ROW) ? 4'd0 : row_q + 4'd1;
                        state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
                    end else begin
                        cnt_d = cnt_q + PH_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Swap only at the frame boundary (end of row 8 drive) or whenever the scan is idle.
    assign swap_apply = pend_q &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_DRIVE) && (row_q == LAST_ROW) && (cnt_q == DWELL_LAST)));

    led_scan_buf u_buf (
        .clk     (XTAL_IN),
        .rst     (RST),
        .wr_en   (WR_EN),
        .wr_row  (WR_ROW),
        .wr_data (WR_DATA),
        .swap    (swap_apply),
        .rd_row  (row_q),
        .rd_data (front_data)
    );

    // Every output decodes flops only; no input reaches an output combinationally.
    assign SWAP_PEND   = pend_q;
    assign SWAP_ACK    = swap_apply;
    assign ROW_SEL     = (state_q == ST_DRIVE) ? row_onehot(row_q) : '0;
    assign COL         = (state_q == ST_DRIVE) ? front_data : '0;
    assign FRAME_START = (state_q == ST_DRIVE) && (row_q == 4'd0) && (cnt_q == '0);

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for two scan controller configurations driven by shared stimulus.
module tb_led_scan_ctrl;

    localparam int DA = 4, BA = 2;
    localparam int DB = 1, BB = 0;

    typedef struct packed {
        logic [8:0] rowsel;
        logic [7:0] col;
        logic       fs;
        logic       ack;
        logic       pend;
    } exp_t;

    typedef struct {
        bit              run;
        int              t;
        bit              pend;
        logic [8:0][7:0] front;
        logic [8:0][7:0] back;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, swap_req;
    logic [3:0] wr_row;
    logic [7:0] wr_data;

    logic       a_pend, a_ack, a_fs, b_pend, b_ack, b_fs;
    logic [8:0] a_rowsel, b_rowsel;
    logic [7:0] a_col, b_col;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    led_scan_ctrl #(.DWELL(DA), .BLANK(BA)) dut_a (
        .XTAL_IN(clk), .RST(rst), .ENABLE(en), .WR_EN(wr_en), .WR_ROW(wr_row),
        .WR_DATA(wr_data), .SWAP_REQ(swap_req), .SWAP_PEND(a_pend), .SWAP_ACK(a_ack),
        .ROW_SEL(a_rowsel), .COL(a_col), .FRAME_START(a_fs)
    );

    led_scan_ctrl #(.DWELL(DB), .BLANK(BB)) dut_b (
        .XTAL_IN(clk), .RST(rst), .ENABLE(en), .WR_EN(wr_en), .WR_ROW(wr_row),
        .WR_DATA(wr_data), .SWAP_REQ(swap_req), .SWAP_PEND(b_pend), .SWAP_ACK(b_ack),
        .ROW_SEL(b_rowsel), .COL(b_col), .FRAME_START(b_fs)
    );

    // Reference: position in the frame is plain time since scan start.
    function automatic exp_t m_out(mdl_t m, int b, int d);
        exp_t e;
        int   p, r, ph;
        e      = '0;
        p      = b + d;
        e.pend = m.pend;
        if (!m.run) begin
            e.ack = m.pend;
        end else begin
            r  = (m.t / p) % 9;
            ph = m.t % p;
            if (ph >= b) begin
                e.rowsel = 9'h100 >> r;
                e.col    = m.front[r];
                e.fs     = (r == 0) && (ph == b);
            end
            e.ack = m.pend && (r == 8) && (ph == p - 1);
        end
        return e;
    endfunction

    function automatic mdl_t m_step(mdl_t m, int b, int d, logic rs, logic en_i, logic we,
                                    logic [3:0] wrow, logic [7:0] wd, logic req);
        mdl_t            n;
        exp_t            cur;
        logic [8:0][7:0] tmp;
        n = m;
        if (rs) begin
            n.run = 0; n.t = 0; n.pend = 0; n.front = '0; n.back = '0;
            return n;
        end
        cur = m_out(m, b, d);
        if (we && (wrow <= 4'd8))
            n.back[wrow] = wd;
        if (cur.ack) begin
            tmp     = n.front;
            n.front = n.back;
            n.back  = tmp;
        end
        n.pend = cur.ack ? req : (m.pend | req);
        if (!en_i) begin
            n.run = 0; n.t = 0;
        end else if (!m.run) begin
            n.run = 1; n.t = 0;
        end else begin
            n.t = (m.t + 1) % (9 * (b + d));
        end
        return n;
    endfunction

    task automatic check(input string name, input exp_t want, input exp_t got);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0t: got rowsel=%h col=%h fs=%b ack=%b pend=%b, want rowsel=%h col=%h fs=%b ack=%b pend=%b",
                      name, $time, got.rowsel, got.col, got.fs, got.ack, got.pend,
                      want.rowsel, want.col, want.fs, want.ack, want.pend);
    endtask

    // Model: sample the inputs on each edge and queue what the next cycle must show.
    initial begin
        mdl_t ma, mb;
        ma = '{run: 0, t: 0, pend: 0, front: '0, back: '0};
        mb = ma;
        forever begin
            @(posedge clk);
            ma = m_step(ma, BA, DA, rst, en, wr_en, wr_row, wr_data, swap_req);
            mb = m_step(mb, BB, DB, rst, en, wr_en, wr_row, wr_data, swap_req);
            q_a.push_back(m_out(ma, BA, DA));
            q_b.push_back(m_out(mb, BB, DB));
        end
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("scan_a", e, {a_rowsel, a_col, a_fs, a_ack, a_pend});
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("scan_b", e, {b_rowsel, b_col, b_fs, b_ack, b_pend});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] row, input logic [7:0] data);
        wr_en = 1'b1; wr_row = row; wr_data = data;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic req();
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: event not seen within budget, got none, want one", name);
    endtask

    initial begin
        int i;
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; swap_req = 1'b0; wr_row = '0; wr_data = '0;
        tick(3);
        rst = 1'b0;
        tick(2);
        en = 1'b1;
        tick(60);

        wr(4'd3, 8'hA5);
        tick(10);
        req();
        tick(120);

        wr(4'd3, 8'hFF);
        wr(4'd12, 8'h55);
        tick(60);

        // Request, then in its apply cycle request again and write row 8.
        req();
        for (i = 0; i < 200 && !a_ack; i++) tick(1);
        if (!a_ack) timeout("apply_cycle_wait");
        else begin
            swap_req = 1'b1; wr_en = 1'b1; wr_row = 4'd8; wr_data = 8'h3C;
            tick(1);
            swap_req = 1'b0; wr_en = 1'b0;
        end

        // Drop enable in the first drive cycle of row 5 while a swap is still pending.
        for (i = 0; i < 200 && a_rowsel != 9'h008; i++) tick(1);
        if (a_rowsel != 9'h008) timeout("row5_wait");
        en = 1'b0;
        tick(4);
        en = 1'b1;
        tick(60);

        for (int k = 0; k < 800; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 99) != 0);
            wr_en    = $urandom_range(0, 1);
            wr_row   = 4'($urandom_range(0, 15));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        rst = 1'b0; en = 1'b1; wr_en = 1'b0; swap_req = 1'b0;
        tick(30);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(60);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
